reaction_timer_core: RTL and testbench
======================================

# reaction_timer_core

Parametrised reaction-timer engine for the lab board: it takes a raw pushbutton and the board clock and produces the stimulus LED, a multi-digit BCD reaction count and a best-time record. It replaces the fixed 2-digit, 3-state timer with a configurable tick rate, digit count, random-delay range and LFSR width. It adds early-press (foul) detection, overflow saturation and a best-time register. BCD outputs feed the existing seg7 decoders, one decoder per digit.

## Interface

- DIV, 500000, Clock cycles per count tick (100 Hz at 50 MHz)
- DIGITS, 3, number of BCD digits in the count and best registers (1..6)
- LFSR_W, 8, random generator width (4..16; other values are an elaboration error)
- MIN_WAIT, 100, minimum random delay in ticks

- Clock  in  1  single clock for all logic
- Reset  in  1  synchronous, active-high; all state returns to reset values on the next Clock edge
- Pushn  in  1  raw pushbutton, active-low, asynchronous
- LED  out  1  stimulus lamp, high only in REACT
- Waiting  out  1  high only in WAIT
- Foul  out  1  high only in FOUL
- Overflow  out  1  count saturated in the current round
- BCD  out  4*DIGITS  current count, digit 0 in bits [3:0]
- Best  out  4*DIGITS  best (lowest) valid reaction time
- BestValid  out  1  Best holds a recorded time

## Operation

- **Input synchronisation.** Pushn passes through a 2-flop synchroniser plus one history flop. Press pulse = history high and synchronised low, so it lasts one cycle per falling edge. A held button gives exactly one press.
- **Tick counter.** Counts 0..DIV-1. Tick is a 1-cycle pulse when the count equals DIV-1. The counter clears on Reset and on every entry to WAIT or REACT.
- **LFSR.** Maximal-length LFSR, LFSR_W bits, seeded to 1 on Reset. It advances every Clock cycle regardless of state and never holds 0.
- **States** (reset state IDLE):
  - IDLE: on press, go to WAIT. Load delay = MIN_WAIT + LFSR value on that edge. Clear BCD and Overflow.
  - WAIT: delay decrements on each tick.
    - Press → FOUL.
    - Delay reaching 0 on a tick → REACT.
  - REACT: BCD increments in decimal on each tick, with ripple carry across DIGITS.
    - At all-9s the count saturates: no wrap, Overflow=1.
    - Press → SHOW. On that edge, if Overflow=0 and (BestValid=0 or BCD < Best), then Best <= BCD and BestValid <= 1.
  - SHOW: BCD held. Press → WAIT: load a new delay, clear BCD and Overflow.
  - FOUL: BCD held at 0, Best untouched. Press → IDLE.
- **Simultaneous events.** Press has priority over a tick in the same cycle.
  - WAIT: press together with the terminal tick goes to FOUL.
  - REACT: a tick coincident with the press is not counted.
- **Comparison.** BCD vs Best is an unsigned numeric comparison over all DIGITS digits, most significant digit first.

## Timing

- **Reset values.** LED, Waiting, Foul, Overflow and BestValid = 0. BCD and Best = 0. State IDLE. LFSR = 1. Tick counter = 0.
- **Reset priority.** Reset overrides every other event, including mid-round. Best is cleared too.
- **Press latency.** If Pushn falls before edge k, the press pulse is high in the cycle after edge k+1. The state changes at edge k+2.
- **Status outputs.** LED, Waiting and Foul are registered decodes of state, valid from the same edge as the state change.
- **WAIT → REACT.** With delay D loaded on entry, LED rises D*DIV Clock cycles after the WAIT entry edge.
- **First count.** The first BCD increment comes DIV cycles after REACT entry. BCD=N at the press means a reaction time of N ticks (±1 tick).
- **Best update.** Best and BestValid update on the same edge as the REACT→SHOW transition.

## Test plan

Bench parameters unless stated: DIV=4, DIGITS=2, LFSR_W=4, MIN_WAIT=2.

1. **Reset.** Assert Reset 3 cycles with Pushn=1 → every output 0, Waiting stays 0 for 50 cycles.
2. **Normal round.** Press from IDLE, record LFSR snapshot S → Waiting=1. LED rises exactly (2+S)*4 cycles after WAIT entry. Press after 37 ticks → BCD=0x37, Best=0x37, BestValid=1, LED=0.
3. **Foul.** Press twice with the second press inside WAIT → Foul=1, LED never rises, Best unchanged. Third press → IDLE, Foul=0.
4. **Best tracking.** Rounds of 20 ticks then 45 ticks → Best=0x20 after each round.
5. **Overflow.** No press for 120 ticks in REACT → BCD=0x99 from tick 99 on, Overflow=1. Press → SHOW, BCD=0x99, Best and BestValid unchanged.
6. **Boundaries.**
   - Press coincident with the terminal WAIT tick → FOUL.
   - Press coincident with a REACT tick → count not incremented.
   - Reset pulse mid-REACT → all reset values on the next edge.
   - Button held low 1000 cycles → exactly one transition.

Source files
------------

// File: rtl/reaction_timer_core.sv
// Reaction-timer engine: debounced-by-sync button, LFSR random delay, BCD
// reaction count with saturation, foul detection and a best-time record.
module reaction_timer_core #(
    parameter int DIV      = 500000,
    parameter int DIGITS   = 3,
    parameter int LFSR_W   = 8,
    parameter int MIN_WAIT = 100
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Pushn,
    output logic                  LED,
    output logic                  Waiting,
    output logic                  Foul,
    output logic                  Overflow,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [4*DIGITS-1:0]   Best,
    output logic                  BestValid
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DLY_W = $clog2(MIN_WAIT + (1 << LFSR_W));
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [15:0] TAP_MASK = lfsr_taps(LFSR_W);

    generate
        if (LFSR_W < 4 || LFSR_W > 16) begin : g_bad_lfsr_w
            $error("reaction_timer_core: LFSR_W must be 4..16");
        end
        if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
            $error("reaction_timer_core: DIGITS must be 1..6");
        end
    endgenerate

    // Decimal increment with ripple carry; caller guarantees the value is not all 9s.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    typedef enum logic [2:0] {IDLE, WAIT, REACT, SHOW, FOUL} state_t;

    state_t             state, state_nxt;
    logic               sync_1, sync_2, hist;
    logic               press;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic [LFSR_W-1:0]  lfsr;
    logic [DLY_W-1:0]   delay;
    logic               load_delay, dec_delay, count_up, save_best, clr_tick;

    assign press = hist & ~sync_2;
    assign tick  = (tick_cnt == CNT_W'(DIV - 1));

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        load_delay = 1'b0;
        dec_delay  = 1'b0;
        count_up   = 1'b0;
        save_best  = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nxt  = WAIT;
                    load_delay = 1'b1;
                end
            end
            WAIT: begin
                if (press) begin
                    state_nxt = FOUL;
                end else if (tick) begin
                    if (delay <= DLY_W'(1)) state_nxt = REACT;
                    else                    dec_delay = 1'b1;
                end
            end
            REACT: begin
                if (press) begin
                    state_nxt = SHOW;
                    save_best = !Overflow && (!BestValid || (BCD < Best));
                end else if (tick) begin
                    count_up = 1'b1;
                end
            end
            SHOW: begin
                if (press) begin
                    state_nxt  = WAIT;
                    load_delay = 1'b1;
                end
            end
            FOUL: begin
                if (press) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        clr_tick = (state_nxt != state) && (state_nxt == WAIT || state_nxt == REACT);
    end

    // Status lamps decode the next state so they change on the same edge as the state.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            LED     <= 1'b0;
            Waiting <= 1'b0;
            Foul    <= 1'b0;
        end else begin
            state   <= state_nxt;
            LED     <= (state_nxt == REACT);
            Waiting <= (state_nxt == WAIT);
            Foul    <= (state_nxt == FOUL);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            hist      <= 1'b1;
            lfsr      <= LFSR_W'(1);
            tick_cnt  <= '0;
            delay     <= '0;
            BCD       <= '0;
            Overflow  <= 1'b0;
            Best      <= '0;
            BestValid <= 1'b0;
        end else begin
            sync_1 <= Pushn;
            sync_2 <= sync_1;
            hist   <= sync_2;
            lfsr   <= {lfsr[LFSR_W-2:0], ^(lfsr & TAP_MASK[LFSR_W-1:0])};

            if (clr_tick || tick) tick_cnt <= '0;
            else                  tick_cnt <= tick_cnt + 1'b1;

            if (load_delay) begin
                delay    <= DLY_W'(MIN_WAIT) + DLY_W'(lfsr);
                BCD      <= '0;
                Overflow <= 1'b0;
            end else if (dec_delay) begin
                delay <= delay - 1'b1;
            end

            if (count_up) begin
                if (BCD == ALL_NINES) Overflow <= 1'b1;
                else                  BCD      <= bcd_inc(BCD);
            end

            if (save_best) begin
                Best      <= BCD;
                BestValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core at DIV=4, DIGITS=2, LFSR_W=4, MIN_WAIT=2.
module tb_reaction_timer_core;

    logic       Clock;
    logic       Reset;
    logic       Pushn;
    logic       LED, Waiting, Foul, Overflow, BestValid;
    logic [7:0] BCD, Best;

    int n_checks = 0;
    int n_fail   = 0;
    int since_rst = 0;

    // Hand-derived sequence of x^4+x^3+1 from seed 1, one entry per clock.
    int unsigned lfsr_seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

    reaction_timer_core #(
        .DIV(4), .DIGITS(2), .LFSR_W(4), .MIN_WAIT(2)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Pushn(Pushn),
        .LED(LED), .Waiting(Waiting), .Foul(Foul), .Overflow(Overflow),
        .BCD(BCD), .Best(Best), .BestValid(BestValid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) since_rst <= Reset ? 0 : since_rst + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Returns just after the edge where the state reacts; s is the LFSR value used there.
    task automatic press(output int s);
        Pushn = 1'b0;
        step(2);
        s = int'(lfsr_seq[since_rst % 15]);
        Pushn = 1'b1;
        step(1);
    endtask

    task automatic start_round(input string tag);
        int s;
        int d;
        press(s);
        check({tag, "_waiting"}, Waiting, 1);
        d = 2 + s;
        step(d * 4 - 1);
        check({tag, "_led_early"}, LED, 0);
        step(1);
        check({tag, "_led_rise"}, LED, 1);
        check({tag, "_waiting_off"}, Waiting, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_led"}, LED, 0);
        check({tag, "_waiting"}, Waiting, 0);
        check({tag, "_foul"}, Foul, 0);
        check({tag, "_ovf"}, Overflow, 0);
        check({tag, "_bcd"}, BCD, 0);
        check({tag, "_best"}, Best, 0);
        check({tag, "_bestvalid"}, BestValid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int d;
        logic seen;
        int rises;
        logic prev;

        Pushn = 1'b1;
        Reset = 1'b1;
        step(3);
        Reset = 1'b0;

        // Reset state and quiet idle
        check_reset_values("rst");
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            seen |= Waiting;
        end
        check("idle_no_wait", seen, 0);

        // Normal round of 37 ticks
        start_round("n37");
        step(4 * 37);
        check("n37_bcd_pre", BCD, 8'h37);
        press(s);
        check("n37_bcd", BCD, 8'h37);
        check("n37_best", Best, 8'h37);
        check("n37_bestvalid", BestValid, 1);
        check("n37_led", LED, 0);

        // Foul: second press lands inside WAIT
        step(4);
        press(s);
        check("foul_wait", Waiting, 1);
        check("foul_bcd_clr", BCD, 0);
        step(3);
        press(s);
        check("foul_flag", Foul, 1);
        check("foul_waiting", Waiting, 0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            seen |= LED;
        end
        check("foul_no_led", seen, 0);
        check("foul_hold", Foul, 1);
        check("foul_bcd", BCD, 0);
        check("foul_best", Best, 8'h37);
        press(s);
        check("foul_exit", Foul, 0);
        check("foul_exit_wait", Waiting, 0);

        // Best tracking: 20 then 45
        step(4);
        start_round("b20");
        step(4 * 20);
        press(s);
        check("b20_bcd", BCD, 8'h20);
        check("b20_best", Best, 8'h20);
        step(4);
        start_round("b45");
        step(4 * 45);
        press(s);
        check("b45_bcd", BCD, 8'h45);
        check("b45_best", Best, 8'h20);
        check("b45_bestvalid", BestValid, 1);

        // Overflow: 120 ticks without a press
        step(4);
        start_round("ovf");
        step(4 * 50);
        check("ovf_bcd50", BCD, 8'h50);
        check("ovf_flag50", Overflow, 0);
        step(4 * 49);
        check("ovf_bcd99", BCD, 8'h99);
        step(4 * 21);
        check("ovf_bcd120", BCD, 8'h99);
        check("ovf_flag120", Overflow, 1);
        press(s);
        check("ovf_show_led", LED, 0);
        check("ovf_show_bcd", BCD, 8'h99);
        check("ovf_show_flag", Overflow, 1);
        check("ovf_best", Best, 8'h20);
        check("ovf_bestvalid", BestValid, 1);

        // Press coincident with the terminal WAIT tick
        step(4);
        press(s);
        d = 2 + s;
        check("term_wait", Waiting, 1);
        check("term_ovf_clr", Overflow, 0);
        step(4 * d - 3);
        press(s);
        check("term_foul", Foul, 1);
        check("term_led", LED, 0);
        step(8);
        check("term_led_later", LED, 0);
        press(s);
        check("term_exit", Foul, 0);

        // Press coincident with a REACT tick
        step(4);
        start_round("ctk");
        step(20);
        check("ctk_bcd_pre", BCD, 8'h05);
        step(1);
        press(s);
        check("ctk_bcd", BCD, 8'h05);
        check("ctk_led", LED, 0);
        check("ctk_best", Best, 8'h05);

        // Reset pulse in the middle of REACT
        step(4);
        start_round("mrs");
        step(40);
        check("mrs_bcd_pre", BCD, 8'h10);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        check_reset_values("mrs");
        step(20);
        check("mrs_idle", Waiting, 0);

        // Button held low for 1000 cycles yields a single press
        step(4);
        Pushn = 1'b0;
        rises = 0;
        prev  = Waiting;
        seen  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (Waiting && !prev) rises++;
            prev = Waiting;
            seen |= Foul;
        end
        check("hold_rises", rises, 1);
        check("hold_no_foul", seen, 0);
        check("hold_react", LED, 1);
        Pushn = 1'b1;
        step(10);
        check("hold_release", LED, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
